uart_pkt_tx: RTL and testbench

- Packetizer that sits directly upstream of the UART transmitter. It consumes 16-bit processing results over a valid/ready stream and buffers them in an internal FIFO.
- Drives the transmitter's start/data/done byte handshake to send framed packets: header, length, payload, checksum.
- Used to ship range/Doppler results to the host over RS-232.

---
 rtl/uart_pkt_tx.sv | 216 +++++++++++++++++++++
 tb/tb_uart_pkt_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_tx.sv
// uart_pkt_tx: packetizer in front of the UART transmitter.
// Buffers 16-bit result words in a FIFO and sends framed packets
// HDR0 HDR1 LEN {hi lo}*LEN CSUM over a start/data/done byte handshake.
// Optional build macro UART_PKT_CRC8_EN replaces the modulo-256 checksum
// with CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR).
module uart_pkt_tx #(
    parameter int          FIFO_DEPTH = 16,
    parameter int          PKT_WORDS  = 8,
    parameter logic [7:0]  HDR0       = 8'hAA,
    parameter logic [7:0]  HDR1       = 8'h55
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic                          flush_i,
    output logic                          tx_start_o,
    output logic [7:0]                    tx_data_o,
    input  logic                          tx_done_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] PKT_L   = LW'(PKT_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        SEND_H0,
        SEND_H1,
        SEND_LEN,
        SEND_PH,
        SEND_PL,
        SEND_CS
    } state_t;

    state_t          r_state;
    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_flush;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;
    logic [7:0]      r_len;
    logic [7:0]      r_words_left;
    logic [7:0]      r_csum;

    logic            w_wr;
    logic            w_pop;
    logic            w_done;
    logic            w_start;
    logic [LW-1:0]   w_len_l;
    logic [7:0]      w_len;
    logic [AW-1:0]   w_rd_next_ptr;
    logic [15:0]     w_rd_word;
    logic [15:0]     w_next_word;

    // One checksum step per transmitted byte; the flavour is chosen at build time.
    function automatic logic [7:0] csumStep(input logic [7:0] acc, input logic [7:0] b);
        logic [7:0] v;
`ifdef UART_PKT_CRC8_EN
        v = acc ^ b;
        for (int i = 0; i < 8; i++) begin
            if (v[7]) begin
                v = {v[6:0], 1'b0} ^ 8'h07;
            end else begin
                v = {v[6:0], 1'b0};
            end
        end
`else
        v = acc + b;
`endif
        return v;
    endfunction

    // A done pulse coinciding with our own start pulse belongs to no byte yet.
    assign w_done        = tx_done_i && !r_tx_start;
    assign w_wr          = s_valid_i && s_ready_o;
    assign w_pop         = (r_state == SEND_PL) && w_done;
    assign w_start       = (r_state == IDLE) &&
                           ((r_level >= PKT_L) || (r_flush && (r_level != '0)));
    assign w_len_l       = (r_level >= PKT_L) ? PKT_L : r_level;
    assign w_len         = 8'(w_len_l);
    assign w_rd_next_ptr = r_rd_ptr + 1'b1;
    assign w_rd_word     = r_mem[r_rd_ptr];
    assign w_next_word   = r_mem[w_rd_next_ptr];

    assign s_ready_o     = (r_level != DEPTH_L);
    assign tx_start_o    = r_tx_start;
    assign tx_data_o     = r_tx_data;
    assign busy_o        = (r_state != IDLE);
    assign fifo_level_o  = r_level;

    // FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= s_data_i;
        end
    end

    // FIFO pointers and level; a write and a pop in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next_ptr;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky flush request, consumed by the packet it triggers; empty-FIFO flushes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush <= 1'b0;
        end else if (w_start) begin
            r_flush <= 1'b0;
        end else if (flush_i && (r_level != '0)) begin
            r_flush <= 1'b1;
        end
    end

    // Packet FSM: each SEND state loads its byte and pulses start on entry, then waits for done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_len        <= 8'h00;
            r_words_left <= 8'h00;
            r_csum       <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state      <= SEND_H0;
                        r_tx_data    <= HDR0;
                        r_tx_start   <= 1'b1;
                        r_len        <= w_len;
                        r_words_left <= w_len;
                        r_csum       <= 8'h00;
                    end
                end
                SEND_H0: begin
                    if (w_done) begin
                        r_state    <= SEND_H1;
                        r_tx_data  <= HDR1;
                        r_tx_start <= 1'b1;
                    end
                end
                SEND_H1: begin
                    if (w_done) begin
                        r_state    <= SEND_LEN;
                        r_tx_data  <= r_len;
                        r_tx_start <= 1'b1;
                        r_csum     <= csumStep(r_csum, r_len);
                    end
                end
                SEND_LEN: begin
                    if (w_done) begin
                        r_state    <= SEND_PH;
                        r_tx_data  <= w_rd_word[15:8];
                        r_tx_start <= 1'b1;
                        r_csum     <= csumStep(r_csum, w_rd_word[15:8]);
                    end
                end
                SEND_PH: begin
                    if (w_done) begin
                        r_state    <= SEND_PL;
                        r_tx_data  <= w_rd_word[7:0];
                        r_tx_start <= 1'b1;
                        r_csum     <= csumStep(r_csum, w_rd_word[7:0]);
                    end
                end
                SEND_PL: begin
                    if (w_done) begin
                        r_tx_start   <= 1'b1;
                        r_words_left <= r_words_left - 8'd1;
                        if (r_words_left > 8'd1) begin
                            r_state   <= SEND_PH;
                            r_tx_data <= w_next_word[15:8];
                            r_csum    <= csumStep(r_csum, w_next_word[15:8]);
                        end else begin
                            r_state   <= SEND_CS;
                            r_tx_data <= r_csum;
                        end
                    end
                end
                SEND_CS: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// tb_uart_pkt_tx: directed bench for uart_pkt_tx with a byte scoreboard.
// A transmitter model answers each start pulse with a done pulse and checks
// every byte against the expected-byte queue. Honours UART_PKT_CRC8_EN.
module tb_uart_pkt_tx;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic        flush_i;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_done_i;
    logic        busy_o;
    logic [4:0]  fifo_level_o;

    int          assertCount = 0;
    int          failCount   = 0;
    int          startCount  = 0;
    bit          doneEnable  = 1'b1;
    int          doneDelay   = 10;
    logic [7:0]  expQ [$];
    logic [15:0] pktW [16];

    uart_pkt_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .flush_i      (flush_i),
        .tx_start_o   (tx_start_o),
        .tx_data_o    (tx_data_o),
        .tx_done_i    (tx_done_i),
        .busy_o       (busy_o),
        .fifo_level_o (fifo_level_o)
    );

    // 10 ns system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] modelStep(input logic [7:0] acc, input logic [7:0] b);
        logic [7:0] v;
`ifdef UART_PKT_CRC8_EN
        v = acc ^ b;
        for (int i = 0; i < 8; i++) begin
            v = v[7] ? ((v << 1) ^ 8'h07) : (v << 1);
        end
`else
        v = acc + b;
`endif
        return v;
    endfunction

    // Push the full expected frame for pktW[first .. first+n-1].
    task automatic pushPacket(input int first, input int n);
        logic [7:0] cs;
        logic [7:0] lenB;
        lenB = 8'(n);
        expQ.push_back(8'hAA);
        expQ.push_back(8'h55);
        expQ.push_back(lenB);
        cs = modelStep(8'h00, lenB);
        for (int i = first; i < first + n; i++) begin
            expQ.push_back(pktW[i][15:8]);
            expQ.push_back(pktW[i][7:0]);
            cs = modelStep(cs, pktW[i][15:8]);
            cs = modelStep(cs, pktW[i][7:0]);
        end
        expQ.push_back(cs);
    endtask

    task automatic applyStimulus(input logic [15:0] w);
        s_data_i  = w;
        s_valid_i = 1'b1;
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
    endtask

    task automatic pulseFlush();
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (expQ.size() == 0 && !busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(ok), 32'd1);
    endtask

    // Transmitter model: checks each started byte and returns done after doneDelay cycles.
    initial begin
        bit pending;
        int cd;
        logic [7:0] e;
        pending   = 1'b0;
        cd        = 0;
        tx_done_i = 1'b0;
        forever begin
            @(negedge clk);
            tx_done_i = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
            end else if (tx_start_o) begin
                startCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_start", 32'(tx_data_o), 32'h100);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("tx_byte", 32'(tx_data_o), 32'(e));
                end
                pending = 1'b1;
                cd      = doneDelay;
            end else if (pending && doneEnable) begin
                if (cd <= 1) begin
                    tx_done_i = 1'b1;
                    pending   = 1'b0;
                end else begin
                    cd--;
                end
            end
        end
    end

    initial begin
        int gap;
        int base;
        bit ok;
        rst_n     = 1'b0;
        s_data_i  = 16'h0000;
        s_valid_i = 1'b0;
        flush_i   = 1'b0;
        #23;
        checkOutput("rst_tx_start", 32'(tx_start_o), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_ready", 32'(s_ready_o), 32'd1);
        checkOutput("rst_level", 32'(fifo_level_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] full 8-word packet");
        for (int i = 0; i < 8; i++) pktW[i] = 16'(i + 1);
        pushPacket(0, 8);
        for (int i = 0; i < 8; i++) applyStimulus(pktW[i]);
        waitIdle("pkt8_complete");
        checkOutput("pkt8_level", 32'(fifo_level_o), 32'd0);

        $display("[TB] flushed 3-word packet");
        pktW[0] = 16'h1234;
        pktW[1] = 16'hABCD;
        pktW[2] = 16'h00FF;
        for (int i = 0; i < 3; i++) applyStimulus(pktW[i]);
        idleCycles(3);
        checkOutput("pkt3_level_before_flush", 32'(fifo_level_o), 32'd3);
        checkOutput("pkt3_idle_before_flush", 32'(busy_o), 32'd0);
        pushPacket(0, 3);
        pulseFlush();
        waitIdle("pkt3_complete");

        $display("[TB] fill with done withheld");
        doneEnable = 1'b0;
        for (int i = 0; i < 16; i++) pktW[i] = 16'h0100 + 16'(i);
        pushPacket(0, 8);
        pushPacket(8, 8);
        for (int i = 0; i < 16; i++) applyStimulus(pktW[i]);
        checkOutput("full_ready", 32'(s_ready_o), 32'd0);
        checkOutput("full_level", 32'(fifo_level_o), 32'd16);
        applyStimulus(16'hDEAD);
        applyStimulus(16'hBEEF);
        checkOutput("full_drop_level", 32'(fifo_level_o), 32'd16);
        doneEnable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("b2b_first_end", 32'(ok), 32'd1);
        gap = 0;
        while (!busy_o && gap < 20) begin
            gap++;
            @(posedge clk);
            #1;
        end
        checkOutput("b2b_idle_gap", 32'(gap), 32'd1);
        waitIdle("b2b_complete");
        checkOutput("b2b_level", 32'(fifo_level_o), 32'd0);

        $display("[TB] flush on empty FIFO");
        pulseFlush();
        idleCycles(20);
        checkOutput("empty_flush_busy", 32'(busy_o), 32'd0);
        pktW[0] = 16'h00FF;
        applyStimulus(pktW[0]);
        idleCycles(20);
        checkOutput("one_word_no_start", 32'(busy_o), 32'd0);
        checkOutput("one_word_level", 32'(fifo_level_o), 32'd1);
        pushPacket(0, 1);
        pulseFlush();
        waitIdle("one_word_complete");

        $display("[TB] reset during payload");
        for (int i = 0; i < 8; i++) pktW[i] = 16'h5A00 + 16'(i);
        pushPacket(0, 8);
        base = startCount;
        for (int i = 0; i < 8; i++) applyStimulus(pktW[i]);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (startCount >= base + 4) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("reach_payload", 32'(ok), 32'd1);
        idleCycles(2);
        checkOutput("payload_byte_held", 32'(tx_data_o), 32'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_tx_start", 32'(tx_start_o), 32'd0);
        checkOutput("midrst_tx_data", 32'(tx_data_o), 32'd0);
        checkOutput("midrst_busy", 32'(busy_o), 32'd0);
        checkOutput("midrst_ready", 32'(s_ready_o), 32'd1);
        checkOutput("midrst_level", 32'(fifo_level_o), 32'd0);
        expQ.delete();
        idleCycles(3);
        rst_n = 1'b1;
        idleCycles(20);
        checkOutput("post_rst_idle", 32'(busy_o), 32'd0);
        for (int i = 0; i < 8; i++) pktW[i] = 16'hC300 + 16'(i * 3);
        pushPacket(0, 8);
        for (int i = 0; i < 8; i++) applyStimulus(pktW[i]);
        waitIdle("post_rst_complete");

        $display("[TB] single zero word");
        pktW[0] = 16'h0000;
        applyStimulus(pktW[0]);
        pushPacket(0, 1);
`ifdef UART_PKT_CRC8_EN
        checkOutput("zero_word_csum_model", 32'(expQ[expQ.size()-1]), 32'h6B);
`else
        checkOutput("zero_word_csum_model", 32'(expQ[expQ.size()-1]), 32'h01);
`endif
        pulseFlush();
        waitIdle("zero_word_complete");
        checkOutput("final_level", 32'(fifo_level_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
